// File: rtl/immediate_encoder.sv
// Searches for the {rot, imm8} operand whose ROR(imm8, 2*rot) reproduces a 32-bit constant.
// Optional macro IMM_ENC_INVERT_EN adds a second pass on ~value that flags the result as inverted.
module immediate_encoder #(
    parameter int ROTS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        ready,
    output logic        done,
    output logic        valid,
    output logic [11:0] shifter_operand,
    output logic        inverted
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] cand, cand_n;
    logic [3:0]  rot_cnt, rot_cnt_n;
    logic        valid_n;
    logic [11:0] operand_n;
    logic        hit;
    logic [3:0]  hit_rot;
    logic [7:0]  hit_imm;
    logic        last_group;
`ifdef IMM_ENC_INVERT_EN
    logic        inv_q, inv_n;
    logic        pass_inv, pass_inv_n;
`endif

    logic [3:0]  grp_rot [ROTS_PER_CYCLE];
    logic [31:0] grp_t   [ROTS_PER_CYCLE];

    // One rotate-left per rotation tested this cycle; a match leaves only the low byte set.
    for (genvar g = 0; g < ROTS_PER_CYCLE; g++) begin : g_rot
        logic [5:0] sh;
        assign grp_rot[g] = rot_cnt + 4'(g);
        assign sh         = {1'b0, grp_rot[g], 1'b0};
        assign grp_t[g]   = (cand << sh) | (cand >> (6'd32 - sh));
    end

    // Scan from the top so the lowest matching rotation is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_rot = '0;
        hit_imm = '0;
        for (int g = ROTS_PER_CYCLE - 1; g >= 0; g--) begin
            if (grp_t[g][31:8] == 24'd0) begin
                hit     = 1'b1;
                hit_rot = grp_rot[g];
                hit_imm = grp_t[g][7:0];
            end
        end
    end

    assign last_group = (rot_cnt == 4'(16 - ROTS_PER_CYCLE));
    assign ready      = (state == IDLE);
    assign done       = (state == DONE);

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        rot_cnt_n = rot_cnt;
        valid_n   = valid;
        operand_n = shifter_operand;
`ifdef IMM_ENC_INVERT_EN
        inv_n      = inv_q;
        pass_inv_n = pass_inv;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SEARCH;
                    cand_n    = value;
                    rot_cnt_n = '0;
                    valid_n   = 1'b0;
                    operand_n = '0;
`ifdef IMM_ENC_INVERT_EN
                    inv_n      = 1'b0;
                    pass_inv_n = 1'b0;
`endif
                end
            end
            SEARCH: begin
                if (hit) begin
                    state_n   = DONE;
                    rot_cnt_n = '0;
                    valid_n   = 1'b1;
                    operand_n = {hit_rot, hit_imm};
`ifdef IMM_ENC_INVERT_EN
                    inv_n = pass_inv;
`endif
                end else if (last_group) begin
                    rot_cnt_n = '0;
`ifdef IMM_ENC_INVERT_EN
                    // Plain pass exhausted: retry once on the complement before giving up.
                    if (!pass_inv) begin
                        pass_inv_n = 1'b1;
                        cand_n     = ~cand;
                    end else begin
                        state_n = DONE;
                    end
`else
                    state_n = DONE;
`endif
                end else begin
                    rot_cnt_n = rot_cnt + 4'(ROTS_PER_CYCLE);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cand            <= '0;
            rot_cnt         <= '0;
            valid           <= 1'b0;
            shifter_operand <= '0;
`ifdef IMM_ENC_INVERT_EN
            inv_q    <= 1'b0;
            pass_inv <= 1'b0;
`endif
        end else begin
            state           <= state_n;
            cand            <= cand_n;
            rot_cnt         <= rot_cnt_n;
            valid           <= valid_n;
            shifter_operand <= operand_n;
`ifdef IMM_ENC_INVERT_EN
            inv_q    <= inv_n;
            pass_inv <= pass_inv_n;
`endif
        end
    end

`ifdef IMM_ENC_INVERT_EN
    assign inverted = inv_q;
`else
    assign inverted = 1'b0;
`endif

endmodule

// File: tb/tb_immediate_encoder.sv
// Scoreboard bench for immediate_encoder: two instances (1 and 4 rotations per cycle) run the same vectors.
// Expectations for the inverted second pass follow IMM_ENC_INVERT_EN.
module tb_immediate_encoder;

    typedef struct {
        logic        v;
        logic [11:0] op;
        logic        inv;
        int          doneEdge;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] value;

    logic        ready1, done1, valid1, inverted1;
    logic [11:0] operand1;
    logic        ready4, done4, valid4, inverted4;
    logic [11:0] operand4;

    int checks = 0;
    int errors = 0;
    int edgeCount = 0;
    sb_entry_t q1[$];
    sb_entry_t q4[$];

    immediate_encoder #(.ROTS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .ready(ready1), .done(done1), .valid(valid1),
        .shifter_operand(operand1), .inverted(inverted1)
    );

    immediate_encoder #(.ROTS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .ready(ready4), .done(done4), .valid(valid4),
        .shifter_operand(operand4), .inverted(inverted4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, edgeCount);
        end
    endtask

    // Monitors: each done pulse pops one expectation, including the edge it was due on.
    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                checkOutput("r1 unexpected done", 32'(done1), 32'd0);
            end else begin
                sb_entry_t e;
                e = q1.pop_front();
                checkOutput("r1 valid", 32'(valid1), 32'(e.v));
                checkOutput("r1 operand", 32'(operand1), 32'(e.op));
                checkOutput("r1 inverted", 32'(inverted1), 32'(e.inv));
                checkOutput("r1 done edge", 32'(edgeCount), 32'(e.doneEdge));
                checkOutput("r1 ready at done", 32'(ready1), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                checkOutput("r4 unexpected done", 32'(done4), 32'd0);
            end else begin
                sb_entry_t e;
                e = q4.pop_front();
                checkOutput("r4 valid", 32'(valid4), 32'(e.v));
                checkOutput("r4 operand", 32'(operand4), 32'(e.op));
                checkOutput("r4 inverted", 32'(inverted4), 32'(e.inv));
                checkOutput("r4 done edge", 32'(edgeCount), 32'(e.doneEdge));
                checkOutput("r4 ready at done", 32'(ready4), 32'd0);
            end
        end
    end

    task automatic waitReady();
        for (int i = 0; i < 50 && !(ready1 && ready4); i++) @(negedge clk);
        if (!(ready1 && ready4)) checkOutput("ready timeout", {30'd0, ready1, ready4}, 32'd3);
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " r1 ready"}, 32'(ready1), 32'd1);
        checkOutput({tag, " r1 done"}, 32'(done1), 32'd0);
        checkOutput({tag, " r1 valid"}, 32'(valid1), 32'd0);
        checkOutput({tag, " r1 operand"}, 32'(operand1), 32'd0);
        checkOutput({tag, " r1 inverted"}, 32'(inverted1), 32'd0);
        checkOutput({tag, " r4 ready"}, 32'(ready4), 32'd1);
        checkOutput({tag, " r4 done"}, 32'(done4), 32'd0);
        checkOutput({tag, " r4 valid"}, 32'(valid4), 32'd0);
        checkOutput({tag, " r4 operand"}, 32'(operand4), 32'd0);
        checkOutput({tag, " r4 inverted"}, 32'(inverted4), 32'd0);
    endtask

    // lat1/lat4: edges after the accepting edge E0 at which each instance shows done.
    task automatic applyStimulus(input logic [31:0] val, input logic v, input logic [11:0] op,
                                 input logic inv, input int lat1, input int lat4, input bit disturb);
        waitReady();
        q1.push_back('{v: v, op: op, inv: inv, doneEdge: edgeCount + 1 + lat1});
        q4.push_back('{v: v, op: op, inv: inv, doneEdge: edgeCount + 1 + lat4});
        start = 1'b1;
        value = val;
        @(negedge clk);
        start = 1'b0;
        value = 32'hDEAD_BEEF;
        if (disturb) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            value = 32'h0000_00FF;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 100 && (q1.size() != 0 || q4.size() != 0); i++) @(negedge clk);
        if (q1.size() != 0 || q4.size() != 0) begin
            checkOutput("done timeout", 32'(q1.size() + q4.size()), 32'd0);
            q1.delete();
            q4.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (2) @(negedge clk);
        checkIdleZero("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(32'h0000_00FF, 1'b1, 12'h0FF, 1'b0, 1, 1, 1'b0);
        applyStimulus(32'hFF00_0000, 1'b1, 12'h4FF, 1'b0, 5, 2, 1'b0);
        applyStimulus(32'hF000_000F, 1'b1, 12'h2FF, 1'b0, 3, 1, 1'b0);
        applyStimulus(32'h0000_0000, 1'b1, 12'h000, 1'b0, 1, 1, 1'b0);
        applyStimulus(32'h8000_0001, 1'b1, 12'h106, 1'b0, 2, 1, 1'b0);
        applyStimulus(32'h4000_0000, 1'b1, 12'h101, 1'b0, 2, 1, 1'b0);
        applyStimulus(32'h00AB_0000, 1'b1, 12'h8AB, 1'b0, 9, 3, 1'b0);
        applyStimulus(32'h0000_03FC, 1'b1, 12'hFFF, 1'b0, 16, 4, 1'b0);
`ifdef IMM_ENC_INVERT_EN
        applyStimulus(32'h0000_0102, 1'b0, 12'h000, 1'b0, 32, 8, 1'b0);
        applyStimulus(32'hFFFF_FF00, 1'b1, 12'h0FF, 1'b1, 17, 5, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 1'b1, 12'h000, 1'b1, 17, 5, 1'b0);
        applyStimulus(32'h0000_0102, 1'b0, 12'h000, 1'b0, 32, 8, 1'b1);
`else
        applyStimulus(32'h0000_0102, 1'b0, 12'h000, 1'b0, 16, 4, 1'b0);
        applyStimulus(32'hFFFF_FF00, 1'b0, 12'h000, 1'b0, 16, 4, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 12'h000, 1'b0, 16, 4, 1'b0);
        applyStimulus(32'h0000_0102, 1'b0, 12'h000, 1'b0, 16, 4, 1'b1);
`endif
        // Leave a valid result behind, then reset in the middle of a long search.
        applyStimulus(32'h0000_00FF, 1'b1, 12'h0FF, 1'b0, 1, 1, 1'b0);
        waitReady();
        start = 1'b1;
        value = 32'h0000_0102;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkIdleZero("mid-search reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkIdleZero("post reset idle");

        applyStimulus(32'hFF00_0000, 1'b1, 12'h4FF, 1'b0, 5, 2, 1'b0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
